hm01b0_sensor_sim: RTL and testbench
====================================

Name: hm01b0_sensor_sim

Overview:
- Behavioural/synthesizable model of the HM01B0 monochrome camera's parallel video port.
- Streams a stored 8-bit grayscale image, frame after frame, with line-valid (hsync) and frame-valid (vsync) framing and a generated pixel clock.
- Feeds the jfpjc JPEG compressor front end (hm01b0_pixclk, hm01b0_pixdata, hm01b0_hsync, hm01b0_vsync) in simulation and bring-up.

Parameters:
- WIDTH, 324, active pixels per line.
- HEIGHT, 244, active lines per frame.
- HBLANK, 20, blank pixel periods appended after each line's active pixels.
- VBLANK, 10, blank lines appended after each frame's active lines.

Ports:
- mclk  input  1  master clock; the only clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pixclk  output  1  pixel clock, mclk/2, registered.
- pixdata  output  8  pixel value; stable across the pixclk rising edge.
- hsync  output  1  line valid; high while pixdata carries an active pixel.
- vsync  output  1  frame valid; high for all active lines of a frame.

Behaviour:
- Storage:
  - Internal memory named hm01b0_image, 8 bits x WIDTH*HEIGHT, row-major (index = row*WIDTH + col).
  - Preloaded by $readmemh from the bench via a hierarchical reference; the name is part of the interface.
  - No write port. Uninitialised content is don't-care.
- Counters:
  - col runs 0..WIDTH+HBLANK-1; row runs 0..HEIGHT+VBLANK-1.
  - col wraps to 0 and increments row; row wraps to 0, so frames repeat indefinitely.
- Reset (reset high at a mclk edge): pixclk=0, pixdata=0, hsync=0, vsync=0, col=0, row=0. Reset mid-frame aborts immediately and restarts at row 0, col 0.
- pixclk: toggles on every mclk edge while reset is low.
- Falling-transition update (edge where pixclk goes 1->0), all registered together:
  - hsync <= (row<HEIGHT) && (col<WIDTH).
  - vsync <= (row<HEIGHT).
  - pixdata <= hsync-next ? hm01b0_image[row*WIDTH+col] : 8'h00.
  - Counters then advance.
- Startup latency:
  - First edge after reset release: pixclk->1.
  - Second edge: pixclk->0 and pixel (0,0) is presented, with hsync=1 and vsync=1.
- Sampling: consumers sample on the pixclk rising edge, one mclk period after the data change.
- Timing totals: one pixel per 2 mclk cycles; a line is (WIDTH+HBLANK)*2 mclk; a frame is (HEIGHT+VBLANK) lines.
- Output shape:
  - hsync deasserts for exactly HBLANK pixel periods between active lines.
  - hsync stays low for all of vertical blank.
  - vsync drops after the last active pixel period's line, including its HBLANK, and rises again at the next frame's row 0.
- Address: row*WIDTH+col computed with width ceil(log2(WIDTH*HEIGHT)); no overflow allowed for default parameters.

Decomposition:
- Shared package jfpjc_pkg holds HM01B0_WIDTH=324, HM01B0_HEIGHT=244 and the pixel type (8-bit unsigned), so the compressor and the model agree on frame geometry.
- One natural sub-module: hm01b0_timing_gen. It owns pixclk, the col/row counters and hsync/vsync, and exports the pixel address; the top holds the image memory and the pixdata register.

Test Plan:
- Reset: hold reset high 5 mclk with mclk running -> pixclk, hsync, vsync, pixdata all 0 throughout.
- Small frame, WIDTH=4, HEIGHT=3, HBLANK=2, VBLANK=1, image bytes 00..0B:
  - Rising-edge pixclk samples read 00,01,02,03 with hsync=1, then 2 samples with hsync=0 and pixdata=00.
  - Then 04..07 and 08..0B follow the same way.
  - Then 6 samples with vsync=0.
  - Then 00 again.
- Period check (defaults): hsync rising edges are exactly 688 mclk apart.
  - 244 hsync pulses per vsync pulse.
  - vsync period = 254*688 mclk.
- Latency: release reset -> first sample of pixel (0,0) on the 3rd mclk rising edge after release (pixclk rising), value = hm01b0_image[0].
- Mid-frame reset: assert reset at row 2, col 1 for 1 mclk -> outputs zero next edge; restart delivers pixel (0,0) with same latency as startup.
- Line-count handshake: bench waits for hsync low->high 260 times -> completes within 2 frames. Every active-line hsync high pulse lasts WIDTH pixel periods = 648 mclk.

Source files
------------

// File: rtl/jfpjc_pkg.sv
// Frame geometry and pixel type shared by the HM01B0 model
// and the jfpjc compressor front end.
package jfpjc_pkg;

  localparam int HM01B0_WIDTH  = 324;
  localparam int HM01B0_HEIGHT = 244;

  typedef logic [7:0] pixel_t;

  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hm01b0_timing_gen.sv
// Pixel clock, col/row scan counters and line/frame valid
// generation for the HM01B0 video port model.
module hm01b0_timing_gen
  import jfpjc_pkg::*;
#(
  parameter int WIDTH  = HM01B0_WIDTH,
  parameter int HEIGHT = HM01B0_HEIGHT,
  parameter int HBLANK = 20,
  parameter int VBLANK = 10,
  parameter int AW     = addr_bits(WIDTH * HEIGHT)
) (
  input  logic          mclk,
  input  logic          reset,
  output logic          pixclk,
  output logic          hsync,
  output logic          vsync,
  output logic          advance,
  output logic          active,
  output logic [AW-1:0] addr
);

  // One spare count of headroom so WIDTH/HEIGHT always fit
  // even with zero blanking.
  localparam int CW = addr_bits(WIDTH + HBLANK + 1);
  localparam int RW = addr_bits(HEIGHT + VBLANK + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + HBLANK - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + VBLANK - 1);
  localparam logic [CW-1:0] COL_ACT  = CW'(WIDTH);
  localparam logic [RW-1:0] ROW_ACT  = RW'(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          row_on;
  logic          col_on;

  assign row_on  = (row < ROW_ACT);
  assign col_on  = (col < COL_ACT);
  assign active  = row_on && col_on;
  assign advance = pixclk;
  assign addr    = AW'(row) * AW'(WIDTH) + AW'(col);

  always_ff @(posedge mclk) begin
    if (reset) begin
      pixclk <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else begin
      pixclk <= ~pixclk;
      // pixclk high here means this edge is its falling transition
      if (pixclk) begin
        hsync <= active;
        vsync <= row_on;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hm01b0_sensor_sim.sv
// HM01B0 parallel video port model: streams hm01b0_image
// frame after frame with hsync/vsync framing.
module hm01b0_sensor_sim
  import jfpjc_pkg::*;
#(
  parameter int WIDTH  = HM01B0_WIDTH,
  parameter int HEIGHT = HM01B0_HEIGHT,
  parameter int HBLANK = 20,
  parameter int VBLANK = 10
) (
  input  logic       mclk,
  input  logic       reset,
  output logic       pixclk,
  output logic [7:0] pixdata,
  output logic       hsync,
  output logic       vsync
);

  localparam int AW = addr_bits(WIDTH * HEIGHT);

  // Loaded externally by hierarchical reference; no write port.
  pixel_t hm01b0_image [WIDTH*HEIGHT];

  logic          advance;
  logic          active;
  logic [AW-1:0] addr;

  hm01b0_timing_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .HBLANK (HBLANK),
    .VBLANK (VBLANK),
    .AW     (AW)
  ) u_timing (
    .mclk    (mclk),
    .reset   (reset),
    .pixclk  (pixclk),
    .hsync   (hsync),
    .vsync   (vsync),
    .advance (advance),
    .active  (active),
    .addr    (addr)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      pixdata <= '0;
    end else if (advance) begin
      pixdata <= active ? hm01b0_image[addr] : '0;
    end
  end

endmodule

// File: tb/tb_hm01b0_sensor_sim.sv
// Bench: small-geometry and default-geometry instances checked
// every mclk against a scan-position model of the video port.
module tb_hm01b0_sensor_sim;

  localparam int SW = 4, SH = 3, SHB = 2, SVB = 1;
  localparam int DW = 324, DH = 244, DHB = 20, DVB = 10;

  logic mclk = 1'b0;
  logic reset = 1'b1;

  logic       s_pixclk, s_hsync, s_vsync;
  logic [7:0] s_pixdata;
  logic       d_pixclk, d_hsync, d_vsync;
  logic [7:0] d_pixdata;

  logic [7:0] img_s [SW*SH];
  logic [7:0] img_d [DW*DH];

  int checks = 0;
  int errors = 0;
  int n_edges = 0;
  int cyc = 0;

  hm01b0_sensor_sim #(
    .WIDTH(SW), .HEIGHT(SH), .HBLANK(SHB), .VBLANK(SVB)
  ) dut_s (
    .mclk(mclk), .reset(reset), .pixclk(s_pixclk),
    .pixdata(s_pixdata), .hsync(s_hsync), .vsync(s_vsync)
  );

  hm01b0_sensor_sim dut_d (
    .mclk(mclk), .reset(reset), .pixclk(d_pixclk),
    .pixdata(d_pixdata), .hsync(d_hsync), .vsync(d_vsync)
  );

  initial forever #5 mclk = ~mclk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // n = mclk edges since reset release; sample k presented
  // at edge 2k+2 and held through edge 2k+3.
  function automatic void model(
    input int n, input int w, input int h,
    input int hb, input int vb,
    output bit pc, output bit hs, output bit vs,
    output int idx, output int r, output int c);
    int k, p;
    pc = ((n % 2) == 1);
    hs = 1'b0; vs = 1'b0; idx = -1; r = -1; c = -1;
    if (n >= 2) begin
      k = (n - 2) / 2;
      p = k % ((w + hb) * (h + vb));
      r = p / (w + hb);
      c = p % (w + hb);
      vs = (r < h);
      hs = vs && (c < w);
      if (hs) idx = r * w + c;
    end
  endfunction

  bit prev_dhs, prev_shs, prev_svs;
  int d_rise = -1, s_vrise = -1, s_hcnt = 0;

  always @(posedge mclk) begin
    bit r_at, pc, hs, vs;
    int idx, r, c, ed;
    r_at = reset;
    #1;
    cyc++;
    if (r_at) n_edges = 0;
    else n_edges++;

    model(n_edges, SW, SH, SHB, SVB, pc, hs, vs, idx, r, c);
    ed = (idx >= 0) ? int'(img_s[idx]) : 0;
    chk("s_pixclk", int'(s_pixclk), int'(pc));
    chk("s_hsync", int'(s_hsync), int'(hs));
    chk("s_vsync", int'(s_vsync), int'(vs));
    chk("s_pixdata", int'(s_pixdata), ed);

    model(n_edges, DW, DH, DHB, DVB, pc, hs, vs, idx, r, c);
    ed = (idx >= 0) ? int'(img_d[idx]) : 0;
    chk("d_pixclk", int'(d_pixclk), int'(pc));
    chk("d_hsync", int'(d_hsync), int'(hs));
    chk("d_vsync", int'(d_vsync), int'(vs));
    chk("d_pixdata", int'(d_pixdata), ed);

    if (r_at) begin
      d_rise = -1; s_vrise = -1; s_hcnt = 0;
    end else begin
      if (d_hsync && !prev_dhs) begin
        if (d_rise >= 0) chk("d_hs_period", cyc - d_rise, 688);
        d_rise = cyc;
      end
      if (!d_hsync && prev_dhs && d_rise >= 0)
        chk("d_hs_width", cyc - d_rise, 648);
      if (s_vsync && !prev_svs) begin
        if (s_vrise >= 0) chk("s_vs_period", cyc - s_vrise, 48);
        s_vrise = cyc;
        s_hcnt = 0;
      end
      if (s_hsync && !prev_shs) s_hcnt++;
      if (!s_vsync && prev_svs && s_vrise >= 0)
        chk("s_lines_per_frame", s_hcnt, SH);
    end
    prev_dhs = d_hsync;
    prev_shs = s_hsync;
    prev_svs = s_vsync;
  end

  int lit_d [25] = '{0, 1, 2, 3, 0, 0, 4, 5, 6, 7, 0, 0,
                     8, 9, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int lit_h [25] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0,
                     1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int lit_v [25] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                     1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    bit pc, hs, vs, found, prev;
    int idx, r, c, rises;

    for (int i = 0; i < SW * SH; i++) begin
      img_s[i] = 8'(i);
      dut_s.hm01b0_image[i] = img_s[i];
    end
    for (int i = 0; i < DW * DH; i++) begin
      img_d[i] = 8'($urandom_range(255));
      dut_d.hm01b0_image[i] = img_d[i];
    end

    repeat (5) begin
      @(posedge mclk);
      #2;
      chk("rst_pixclk", int'(s_pixclk | d_pixclk), 0);
      chk("rst_sync", int'({s_hsync, s_vsync, d_hsync, d_vsync}), 0);
      chk("rst_pixdata", int'(s_pixdata | d_pixdata), 0);
    end
    @(negedge mclk);
    reset = 1'b0;

    repeat (3) @(posedge mclk);
    #2;
    chk("lat_pixclk", int'(d_pixclk), 1);
    chk("lat_hsync", int'(d_hsync), 1);
    chk("lat_pixdata", int'(d_pixdata), int'(img_d[0]));

    for (int k = 0; k < 25; k++) begin
      chk("lit_pixdata", int'(s_pixdata), lit_d[k]);
      chk("lit_hsync", int'(s_hsync), lit_h[k]);
      chk("lit_vsync", int'(s_vsync), lit_v[k]);
      repeat (2) @(posedge mclk);
      #2;
    end

    repeat (3000) @(negedge mclk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge mclk);
      model(n_edges, SW, SH, SHB, SVB, pc, hs, vs, idx, r, c);
      if (r == 2 && c == 1) found = 1'b1;
    end
    chk("midrst_found", int'(found), 1);
    reset = 1'b1;
    @(posedge mclk);
    #2;
    chk("midrst_zero", int'({s_pixclk, s_hsync, s_vsync}), 0);
    chk("midrst_pixdata", int'(s_pixdata), 0);
    @(negedge mclk);
    reset = 1'b0;
    repeat (3) @(posedge mclk);
    #2;
    chk("relat_pixclk", int'(s_pixclk), 1);
    chk("relat_hsync", int'(s_hsync), 1);
    chk("relat_pixdata", int'(s_pixdata), int'(img_s[0]));
    chk("relat_d_pixdata", int'(d_pixdata), int'(img_d[0]));

    rises = 0;
    prev = s_hsync;
    for (int i = 0; i < 96 && rises < SH + 1; i++) begin
      @(posedge mclk);
      #2;
      if (s_hsync && !prev) rises++;
      prev = s_hsync;
    end
    chk("handshake_lines", rises, SH + 1);

    repeat (2000) @(negedge mclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
